// File: rtl/mult_err_pkg.sv
// mult_err_pkg: shared state encoding and width helpers for the multiplier error sweep
package mult_err_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;
  localparam int W_DEF = 8;
  function automatic int PW(input int w);
    return 2 * w;
  endfunction
  function automatic int SW(input int w);
    return 4 * w;
  endfunction
  function automatic int CW(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/mult_err_sweep_err_accum.sv
// err_accum: abs-diff stage followed by error count, error sum and first-max tracker
module err_accum
  import mult_err_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               stall,
  input  logic               vld,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [PW(W)-1:0]   apx,
  output logic               pend,
  output logic [CW(W)-1:0]   err_cnt,
  output logic [SW(W)-1:0]   err_sum,
  output logic [PW(W)-1:0]   err_max,
  output logic [W-1:0]       err_max_a,
  output logic [W-1:0]       err_max_b
);
  localparam int P_W = PW(W);
  localparam int S_W = SW(W);
  localparam int C_W = CW(W);
  logic [P_W-1:0] exact, mag_q, mag_d, max_q, max_d;
  logic [W-1:0] pa_q, pa_d, pb_q, pb_d, ma_q, ma_d, mb_q, mb_d;
  logic pv_q, pv_d, mis_q, mis_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [S_W-1:0] sum_q, sum_d;
  always_comb begin
    exact = a * b;
    pv_d = pv_q;
    mis_d = mis_q;
    mag_d = mag_q;
    pa_d = pa_q;
    pb_d = pb_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    max_d = max_q;
    ma_d = ma_q;
    mb_d = mb_q;
    if (clr) begin
      pv_d = 1'b0;
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
      ma_d = '0;
      mb_d = '0;
    end else if (!stall) begin
      pv_d = vld;
      mis_d = exact != apx;
      mag_d = exact >= apx ? exact - apx : apx - exact;
      pa_d = a;
      pb_d = b;
      if (pv_q) begin
        cnt_d = cnt_q + C_W'(mis_q);
        sum_d = sum_q + S_W'(mag_q);
        // strict compare keeps the lowest-index pair on ties
        max_d = mag_q > max_q ? mag_q : max_q;
        ma_d = mag_q > max_q ? pa_q : ma_q;
        mb_d = mag_q > max_q ? pb_q : mb_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= 1'b0;
      mis_q <= 1'b0;
      mag_q <= '0;
      pa_q <= '0;
      pb_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
    end else begin
      pv_q <= pv_d;
      mis_q <= mis_d;
      mag_q <= mag_d;
      pa_q <= pa_d;
      pb_q <= pb_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
    end
  end
  assign pend = pv_q;
  assign err_cnt = cnt_q;
  assign err_sum = sum_q;
  assign err_max = max_q;
  assign err_max_a = ma_q;
  assign err_max_b = mb_q;
endmodule

// File: rtl/mult_err_sweep.sv
// mult_err_sweep: exhaustive operand sweep and error characterisation of an approximate multiplier
module mult_err_sweep
  import mult_err_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int APX_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [PW(W)-1:0]   apx_p,
  output logic [W-1:0]       op_a,
  output logic [W-1:0]       op_b,
  output logic               busy,
  output logic               done,
  output logic [CW(W)-1:0]   err_cnt,
  output logic [SW(W)-1:0]   err_sum,
  output logic [PW(W)-1:0]   err_max,
  output logic [W-1:0]       err_max_a,
  output logic [W-1:0]       err_max_b
);
  localparam int P_W = PW(W);
  state_e state_q, state_d;
  logic [P_W-1:0] idx_q, idx_d;
  logic [APX_LAT:0] vld_q, vld_d;
  // operand pairs travel alongside the multiplier under test so the exact product lines up with apx_p
  logic [APX_LAT:0][P_W-1:0] ops_q, ops_d;
  logic done_q, done_d, clr, pend;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vld_d = vld_q;
    ops_d = ops_q;
    done_d = 1'b0;
    clr = 1'b0;
    if (state_q == IDLE) begin
      clr = start;
      state_d = start ? SWEEP : IDLE;
      idx_d = start ? '0 : idx_q;
    end else if (!stall) begin
      for (int k = 1; k <= APX_LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        ops_d[k] = ops_q[k-1];
      end
      vld_d[0] = state_q == SWEEP;
      if (state_q == SWEEP) begin
        ops_d[0] = idx_q;
        idx_d = idx_q + P_W'(1);
        state_d = idx_q == '1 ? DRAIN : SWEEP;
      end else if (pend && !(|vld_q)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      vld_q <= '0;
      ops_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      ops_q <= ops_d;
      done_q <= done_d;
    end
  end
  err_accum #(.W(W)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .stall(stall),
    .vld(vld_q[APX_LAT]),
    .a(ops_q[APX_LAT][P_W-1:W]),
    .b(ops_q[APX_LAT][W-1:0]),
    .apx(apx_p),
    .pend(pend),
    .err_cnt(err_cnt),
    .err_sum(err_sum),
    .err_max(err_max),
    .err_max_a(err_max_a),
    .err_max_b(err_max_b)
  );
  assign op_a = ops_q[0][P_W-1:W];
  assign op_b = ops_q[0][W-1:0];
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule
